// File: rtl/mode_controller_pkg.sv
// Shared types and constants for the clock datapath sequencer: function modes,
// BCD time-bus width and field offsets.
package mode_controller_pkg;

    typedef enum logic [1:0] {
        MODE_CLOCK     = 2'd0,
        MODE_ALARM     = 2'd1,
        MODE_STOPWATCH = 2'd2,
        MODE_TIMER     = 2'd3
    } mode_e;

    localparam int TIME_W = 36;

    // BCD layout of the time bus: HH MM SS mmm, most significant first
    localparam int BCD_MS_LSB = 0;
    localparam int BCD_SS_LSB = 12;
    localparam int BCD_MM_LSB = 20;
    localparam int BCD_HH_LSB = 28;

    typedef logic [TIME_W-1:0] time_t;

    function automatic mode_e next_mode(input mode_e m);
        return mode_e'(m + 2'd1);
    endfunction

endpackage

// File: rtl/mode_controller_if.sv
// Bundle of button, unit time-bus and display signals around the mode controller.
// The slave modport is the controller's view; master is the surrounding system.
interface mode_controller_if;
    import mode_controller_pkg::*;

    logic       btn_u, btn_d, btn_l, btn_r, btn_c;
    logic [3:0] edit_in;
    time_t      time_clk, time_alm, time_sw, time_tmr;

    logic       tick;
    mode_e      mode;
    logic [3:0] ev_d, ev_l, ev_r, ev_c;
    time_t      disp_time;
    logic       disp_edit;
    logic       disp_blank;

    modport master (
        output btn_u, btn_d, btn_l, btn_r, btn_c, edit_in,
        output time_clk, time_alm, time_sw, time_tmr,
        input  tick, mode, ev_d, ev_l, ev_r, ev_c, disp_time, disp_edit, disp_blank
    );

    modport slave (
        input  btn_u, btn_d, btn_l, btn_r, btn_c, edit_in,
        input  time_clk, time_alm, time_sw, time_tmr,
        output tick, mode, ev_d, ev_l, ev_r, ev_c, disp_time, disp_edit, disp_blank
    );

endinterface

// File: rtl/mode_controller_btn_debounce.sv
// Button conditioner: 2-flop synchronizer, stability counter and a one-cycle
// press pulse on an accepted release-to-press change.
module btn_debounce #(
    parameter int DEB_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);
    localparam int CW = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic          sync_p0, sync_p1;
    logic          fill_p0, fill_p1;
    logic          level;
    logic          armed;
    logic [CW-1:0] cnt;

    // armed stays low until a genuine released sample is seen after reset, so a
    // button held through reset is absorbed silently instead of producing a press
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            fill_p0 <= 1'b0;
            fill_p1 <= 1'b0;
            level   <= 1'b0;
            armed   <= 1'b0;
            cnt     <= '0;
            press   <= 1'b0;
        end else begin
            sync_p0 <= btn;
            sync_p1 <= sync_p0;
            fill_p0 <= 1'b1;
            fill_p1 <= fill_p0;
            press   <= 1'b0;
            if (fill_p1 && !sync_p1)
                armed <= 1'b1;
            if (sync_p1 != level) begin
                if (cnt == CNT_LAST) begin
                    level <= sync_p1;
                    cnt   <= '0;
                    press <= sync_p1 & armed;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/mode_controller.sv
// Top-level sequencer: tick prescaler, button conditioning, function-mode FSM,
// event routing to the active unit and the registered display mux with edit blink.
module mode_controller
    import mode_controller_pkg::*;
#(
    parameter int CLK_HZ      = 100_000_000,
    parameter int TICK_HZ     = 1000,
    parameter int DEB_CYCLES  = 1_000_000,
    parameter int BLINK_TICKS = 250
) (
    input  logic       clk,
    input  logic       rst,
    mode_controller_if.slave bus
);
    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = $clog2(DIV);
    localparam int BW  = $clog2(BLINK_TICKS + 1);
    localparam logic [PW-1:0] PRE_LAST   = PW'(DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);
    localparam int B_U = 0, B_D = 1, B_L = 2, B_R = 3, B_C = 4;

    logic [4:0]    btn_raw;
    logic [4:0]    press;
    logic [PW-1:0] pre_cnt;
    logic          tick;
    mode_e         mode_q, mode_d;
    logic [3:0]    route;
    time_t         mux_time;
    time_t         disp_time_p1;
    logic          disp_edit_p1;
    logic [BW-1:0] blink_cnt;
    logic          blank_q;

    assign btn_raw = {bus.btn_c, bus.btn_r, bus.btn_l, bus.btn_d, bus.btn_u};

    for (genvar i = 0; i < 5; i++) begin : g_deb
        btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
            .clk   (clk),
            .rst   (rst),
            .btn   (btn_raw[i]),
            .press (press[i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst)
            pre_cnt <= '0;
        else
            pre_cnt <= (pre_cnt == PRE_LAST) ? '0 : pre_cnt + 1'b1;
    end

    assign tick     = (pre_cnt == PRE_LAST);
    assign bus.tick = tick;

    always_ff @(posedge clk) begin
        if (rst)
            mode_q <= MODE_CLOCK;
        else
            mode_q <= mode_d;
    end

    // Presses coinciding with press_u still route to the mode in force this cycle
    always_comb begin
        mode_d   = mode_q;
        route    = 4'b0001 << mode_q;
        bus.ev_d = '0;
        bus.ev_l = '0;
        bus.ev_r = '0;
        bus.ev_c = '0;
        if (press[B_U] && !bus.edit_in[mode_q])
            mode_d = next_mode(mode_q);
        if (press[B_D]) bus.ev_d = route;
        if (press[B_L]) bus.ev_l = route;
        if (press[B_R]) bus.ev_r = route;
        if (press[B_C]) bus.ev_c = route;
    end

    assign bus.mode = mode_q;

    always_comb begin
        mux_time = bus.time_clk;
        unique case (mode_q)
            MODE_CLOCK:     mux_time = bus.time_clk;
            MODE_ALARM:     mux_time = bus.time_alm;
            MODE_STOPWATCH: mux_time = bus.time_sw;
            MODE_TIMER:     mux_time = bus.time_tmr;
        endcase
    end

    // Display stage: one register between the mode mux and the display path
    always_ff @(posedge clk) begin
        if (rst) begin
            disp_time_p1 <= '0;
            disp_edit_p1 <= 1'b0;
        end else begin
            disp_time_p1 <= mux_time;
            disp_edit_p1 <= bus.edit_in[mode_q];
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !disp_edit_p1) begin
            blink_cnt <= '0;
            blank_q   <= 1'b0;
        end else if (tick) begin
            if (blink_cnt == BLINK_LAST) begin
                blink_cnt <= '0;
                blank_q   <= ~blank_q;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    assign bus.disp_time  = disp_time_p1;
    assign bus.disp_edit  = disp_edit_p1;
    assign bus.disp_blank = blank_q & disp_edit_p1;

endmodule
